// File: rtl/alu_result_collector.sv
// alu_result_collector: gathers one-cycle result strobes from NCH ALU channels
// into per-channel FIFOs and serialises them through a single output register
// using round-robin arbitration. Each delivered record carries an 8-bit
// sequence number.
// Optional feature macro: COLLECTOR_OVF_COUNT_EN adds saturating per-channel
// drop counters on the ovf_count port.
module alu_result_collector #(
  parameter int NCH   = 2,
  parameter int RES_W = 16,
  parameter int DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NCH-1:0]                       in_done,
  input  logic [NCH*RES_W-1:0]                 in_result,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [RES_W-1:0]                     out_result,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] out_ch,
  output logic [7:0]                           out_seq,
  output logic [NCH-1:0]                       drop_flag
`ifdef COLLECTOR_OVF_COUNT_EN
  ,
  output logic [NCH*8-1:0]                     ovf_count
`endif
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CH_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CH_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CH_LAST  = CW'(NCH - 1);

  logic [RES_W-1:0] r_mem  [NCH][DEPTH];
  logic [PW-1:0]    r_wptr [NCH];
  logic [PW-1:0]    r_rptr [NCH];

  logic             r_valid;
  logic [RES_W-1:0] r_result;
  logic [CW-1:0]    r_ch;
  logic [7:0]       r_seq;
  logic [CW-1:0]    r_rr;
  logic [NCH-1:0]   r_drop;

  logic [NCH-1:0]   w_empty;
  logic [NCH-1:0]   w_full;
  logic [NCH-1:0]   w_push;
  logic [NCH-1:0]   w_pop;
  logic [NCH-1:0]   w_drop;
  logic             w_any;
  logic [CW-1:0]    w_win;
  logic [CW-1:0]    w_idx;
  int               w_sum;
  logic             w_load;
  logic             w_xfer;
  logic [RES_W-1:0] w_rd_data;

  // FIFO status: the extra pointer bit separates full from empty on wrap.
  always_comb begin
    w_empty = {NCH{1'b0}};
    w_full  = {NCH{1'b0}};
    for (int c = 0; c < NCH; c++) begin
      w_empty[c] = (r_wptr[c] == r_rptr[c]);
      w_full[c]  = (r_wptr[c][PW-1] != r_rptr[c][PW-1]) &&
                   (r_wptr[c][AW-1:0] == r_rptr[c][AW-1:0]);
    end
  end

  // Round-robin search over non-empty FIFOs starting at r_rr.
  always_comb begin
    w_any = 1'b0;
    w_win = CH_ZERO;
    w_idx = CH_ZERO;
    w_sum = 0;
    for (int i = 0; i < NCH; i++) begin
      w_sum = int'(r_rr) + i;
      w_idx = (w_sum >= NCH) ? CW'(w_sum - NCH) : CW'(w_sum);
      if (!w_any && !w_empty[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end else begin
        w_any = w_any;
      end
    end
  end

  // Output handshake, FIFO pop/push/drop decisions and winner read data.
  always_comb begin
    w_xfer    = r_valid && out_ready;
    w_load    = w_any && (!r_valid || out_ready);
    w_rd_data = r_mem[w_win][r_rptr[w_win][AW-1:0]];
    w_pop     = {NCH{1'b0}};
    w_push    = {NCH{1'b0}};
    w_drop    = {NCH{1'b0}};
    for (int c = 0; c < NCH; c++) begin
      w_pop[c]  = w_load && (w_win == CW'(c));
      w_push[c] = in_done[c] && (!w_full[c] || w_pop[c]);
      w_drop[c] = in_done[c] && w_full[c] && !w_pop[c];
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (w_push[c]) begin
        r_mem[c][r_wptr[c][AW-1:0]] <= in_result[c*RES_W +: RES_W];
      end
    end
  end

  // Pointers, output register, sequence counter, arbiter pointer, drop flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        r_wptr[c] <= {PW{1'b0}};
        r_rptr[c] <= {PW{1'b0}};
      end
      r_valid  <= 1'b0;
      r_result <= {RES_W{1'b0}};
      r_ch     <= CH_ZERO;
      r_seq    <= 8'd0;
      r_rr     <= CH_ZERO;
      r_drop   <= {NCH{1'b0}};
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (w_push[c]) r_wptr[c] <= r_wptr[c] + PTR_ONE;
        if (w_pop[c])  r_rptr[c] <= r_rptr[c] + PTR_ONE;
      end
      r_drop <= r_drop | w_drop;
      if (w_load) begin
        r_valid  <= 1'b1;
        r_result <= w_rd_data;
        r_ch     <= w_win;
        r_rr     <= (w_win == CH_LAST) ? CH_ZERO : (w_win + CH_ONE);
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
      if (w_xfer) begin
        r_seq <= r_seq + 8'd1;
      end
    end
  end

  assign out_valid  = r_valid;
  assign out_result = r_result;
  assign out_ch     = r_ch;
  assign out_seq    = r_seq;
  assign drop_flag  = r_drop;

`ifdef COLLECTOR_OVF_COUNT_EN
  logic [NCH*8-1:0] r_ovf;

  // Saturating per-channel count of discarded writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= {(NCH*8){1'b0}};
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (w_drop[c] && (r_ovf[c*8 +: 8] != 8'hFF)) begin
          r_ovf[c*8 +: 8] <= r_ovf[c*8 +: 8] + 8'd1;
        end
      end
    end
  end

  assign ovf_count = r_ovf;
`endif

endmodule

// File: doc/alu_result_collector.md
ALU_RESULT_COLLECTOR -- requirements
Module: alu_result_collector

Interface
REQ-001 SHALL have parameter NCH, default 2, number of ALU result channels (1..8).
REQ-002 SHALL have parameter RES_W, default 16, result width per channel.
REQ-003 SHALL have parameter DEPTH, default 4, per-channel FIFO entries (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_done  input  NCH  per-channel one-cycle result strobe.
REQ-007 SHALL have port in_result  input  NCH*RES_W  per-channel result, channel c at bits [c*RES_W +: RES_W].
REQ-008 SHALL have port out_valid  output  1  output record valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts record.
REQ-010 SHALL have port out_result  output  RES_W  result of the current record.
REQ-011 SHALL have port out_ch  output  max(1,$clog2(NCH))  source channel of the current record.
REQ-012 SHALL have port out_seq  output  8  running record sequence number.
REQ-013 SHALL have port drop_flag  output  NCH  sticky per-channel overflow indicator.
REQ-014 SHALL have port ovf_count  output  NCH*8  per-channel drop counters (present only under COLLECTOR_OVF_COUNT_EN).

Function
REQ-015 SHALL write in_result[c] into FIFO c on each rising edge where in_done[c]=1 and FIFO c is not full.
REQ-016 SHALL, when FIFO c is full and in_done[c]=1, discard the result unless FIFO c is popped in the same cycle, in which case the write is accepted.
REQ-017 SHALL set drop_flag[c] on every discarded write; it stays set until reset.
REQ-018 SHALL hold one output register; a transfer occurs on any edge with out_valid=1 and out_ready=1.
REQ-019 SHALL load the output register from the arbiter's winner when the register is empty or is transferring in that cycle (no bubble under continuous out_ready=1).
REQ-020 SHALL arbitrate round-robin among non-empty FIFOs, searching from the channel after the last granted channel, wrapping NCH-1 -> 0.
REQ-021 SHALL hold out_result, out_ch, out_seq stable while out_valid=1 and out_ready=0.
REQ-022 SHALL give latency of one cycle: a result strobed at edge k into an empty collector drives out_valid=1 after edge k+1.
REQ-023 SHALL increment out_seq by 1 on every transfer, wrapping 255 -> 0; out_seq of the first record after reset is 0.
REQ-024 SHALL deliver records per channel in strobe order; no record loss except via REQ-016.
REQ-025 SHALL keep FIFO pointers $clog2(DEPTH)+1 bits wide so full and empty are distinguished on wrap-around.

Reset
REQ-026 SHALL, on reset assertion, immediately clear all FIFOs, the output register, out_valid=0, out_result=0, out_ch=0, out_seq=0, drop_flag=0, ovf_count=0, and the round-robin pointer to channel 0 (priority starts at channel 0).
REQ-027 SHALL discard in-flight records on reset mid-operation; in_done is ignored while reset=1.

Configuration
REQ-028 SHALL, with COLLECTOR_OVF_COUNT_EN defined, include ovf_count: counter c increments on each discarded write on channel c and saturates at 255.
REQ-029 SHALL, without COLLECTOR_OVF_COUNT_EN, omit the ovf_count port and counters entirely; drop_flag behaviour is unchanged.

Verification
REQ-030 SHALL verify single result: in_done[0] with 16'h00C3, out_ready=1 -> out_valid one cycle later, out_result=16'h00C3, out_ch=0, out_seq=0.
REQ-031 SHALL verify fairness: both channels strobed on 3 consecutive cycles (ch0 A1..A3, ch1 B1..B3), out_ready=1 -> order A1,B1,A2,B2,A3,B3, out_seq 0..5.
REQ-032 SHALL verify overflow: out_ready=0, 6 strobes on ch1 with DEPTH=4 -> outputs 1 held + 4 queued, drop_flag[1]=1, ovf_count ch1=1; drain yields the first 5 in order.
REQ-033 SHALL verify backpressure: out_ready toggling 0/1 every cycle for 10 records -> each record held stable while stalled, no duplicates, none lost.
REQ-034 SHALL verify sequence wrap: 257 transfers -> out_seq 255 then 0 then 1.
REQ-035 SHALL verify reset mid-burst: reset asserted with 3 records queued -> out_valid=0 at once; after release, new strobe emerges with out_seq=0, out_ch from channel 0 priority.
